// File: rtl/byte_addr_data_memory.sv
// Byte-addressed data memory with sized/extended loads, byte-lane stores,
// fixed-latency response pipeline and a self-clearing INIT sweep.
`timescale 1ns/1ps
module byte_addr_data_memory #(
    parameter int unsigned NB_DATA  = 32,
    parameter int unsigned DEPTH    = 1024,
    parameter int unsigned NB_ADDR  = 32,
    parameter int unsigned READ_LAT = 1
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_clear,
    input  logic               i_req_valid,
    output logic               o_req_ready,
    input  logic               i_req_we,
    input  logic [1:0]         i_req_size,
    input  logic               i_req_unsigned,
    input  logic [NB_ADDR-1:0] i_req_addr,
    input  logic [NB_DATA-1:0] i_req_wdata,
    output logic               o_rsp_valid,
    output logic [NB_DATA-1:0] o_rsp_data,
    output logic               o_rsp_err,
    input  logic [NB_ADDR-1:0] i_addr_debug,
    output logic [NB_DATA-1:0] o_data_debug
);

    localparam int unsigned NB_BYTES   = NB_DATA / 8;
    localparam int unsigned LANE_BITS  = $clog2(NB_BYTES);
    localparam int unsigned DEPTH_BITS = $clog2(DEPTH);
    localparam int unsigned IDX_W      = NB_ADDR - LANE_BITS;
    localparam int unsigned SHAMT_W    = LANE_BITS + 3;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [DEPTH_BITS-1:0]   r_cnt;
    logic [DEPTH_BITS-1:0]   w_cnt_next;

    logic [NB_DATA-1:0]      r_mem [DEPTH];

    logic [IDX_W-1:0]        w_index;
    logic [LANE_BITS-1:0]    w_offset;
    logic [DEPTH_BITS-1:0]   w_widx;
    logic [SHAMT_W-1:0]      w_shamt;
    logic                    w_oor;
    logic                    w_misalign;
    logic                    w_size_bad;
    logic                    w_err;
    logic                    w_acc;
    logic                    w_wr_en;
    logic [7:0]              w_mask8;
    logic [NB_BYTES-1:0]     w_be;
    logic [NB_DATA-1:0]      w_wdata_sh;
    logic [NB_DATA-1:0]      w_rd_word;
    logic [NB_DATA-1:0]      w_shifted;
    logic [NB_DATA-1:0]      w_ext;
    logic                    w_in_valid;
    logic                    w_in_err;
    logic [NB_DATA-1:0]      w_in_data;
    logic                    w_dbg_oor;

    logic                    r_pv [READ_LAT];
    logic                    r_pe [READ_LAT];
    logic [NB_DATA-1:0]      r_pd [READ_LAT];

    // State register and clear-sweep counter
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_INIT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next state; ready drops combinationally so a request coinciding with clear is refused
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        o_req_ready  = 1'b0;
        case (r_state)
            ST_INIT: begin
                w_cnt_next = r_cnt + DEPTH_BITS'(1);
                if (r_cnt == DEPTH_BITS'(DEPTH - 1)) begin
                    w_state_next = ST_RUN;
                    w_cnt_next   = '0;
                end
            end
            ST_RUN: begin
                o_req_ready = !i_clear;
                if (i_clear) begin
                    w_state_next = ST_INIT;
                    w_cnt_next   = '0;
                end
            end
            default: begin
                w_state_next = ST_INIT;
                w_cnt_next   = '0;
            end
        endcase
    end

    // Address decode and error classification
    always_comb begin
        w_index    = i_req_addr[NB_ADDR-1:LANE_BITS];
        w_offset   = i_req_addr[LANE_BITS-1:0];
        w_widx     = w_index[DEPTH_BITS-1:0];
        w_shamt    = {w_offset, 3'b000};
        w_oor      = 64'(w_index) >= 64'(DEPTH);
        w_size_bad = (i_req_size == 2'b11) && (NB_DATA == 32);
        w_misalign = 1'b0;
        w_mask8    = 8'h01;
        case (i_req_size)
            2'b00: begin
                w_misalign = 1'b0;
                w_mask8    = 8'h01;
            end
            2'b01: begin
                w_misalign = w_offset[0];
                w_mask8    = 8'h03;
            end
            2'b10: begin
                w_misalign = |w_offset[1:0];
                w_mask8    = 8'h0F;
            end
            default: begin
                w_misalign = |w_offset;
                w_mask8    = 8'hFF;
            end
        endcase
        w_err      = w_oor || w_misalign || w_size_bad;
        w_acc      = i_req_valid && o_req_ready;
        w_wr_en    = w_acc && i_req_we && !w_err;
        w_be       = NB_BYTES'(w_mask8) << w_offset;
        w_wdata_sh = i_req_wdata << w_shamt;
    end

    // Load path: read addressed word, right-justify lanes, then extend
    always_comb begin
        w_rd_word = r_mem[w_widx];
        w_shifted = w_rd_word >> w_shamt;
        w_ext     = w_shifted;
        case (i_req_size)
            2'b00: w_ext = i_req_unsigned ? NB_DATA'(w_shifted[7:0])
                                          : NB_DATA'($signed(w_shifted[7:0]));
            2'b01: w_ext = i_req_unsigned ? NB_DATA'(w_shifted[15:0])
                                          : NB_DATA'($signed(w_shifted[15:0]));
            2'b10: w_ext = i_req_unsigned ? NB_DATA'(w_shifted[31:0])
                                          : NB_DATA'($signed(w_shifted[31:0]));
            default: w_ext = w_shifted;
        endcase
        w_in_valid = w_acc;
        w_in_err   = w_acc && w_err;
        w_in_data  = (w_acc && !w_err && !i_req_we) ? w_ext : '0;
    end

    // Array: INIT sweep zeroes one word per cycle; otherwise byte-lane stores
    always_ff @(posedge i_clk) begin
        if (r_state == ST_INIT) begin
            r_mem[r_cnt] <= '0;
        end else if (w_wr_en) begin
            for (int l = 0; l < int'(NB_BYTES); l++) begin
                if (w_be[l]) begin
                    r_mem[w_widx][l*8 +: 8] <= w_wdata_sh[l*8 +: 8];
                end
            end
        end
    end

    // Response pipeline; free-running so in-flight responses survive a clear
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int s = 0; s < int'(READ_LAT); s++) begin
                r_pv[s] <= 1'b0;
                r_pe[s] <= 1'b0;
                r_pd[s] <= '0;
            end
        end else begin
            r_pv[0] <= w_in_valid;
            r_pe[0] <= w_in_err;
            r_pd[0] <= w_in_data;
            for (int s = 1; s < int'(READ_LAT); s++) begin
                r_pv[s] <= r_pv[s-1];
                r_pe[s] <= r_pe[s-1];
                r_pd[s] <= r_pd[s-1];
            end
        end
    end

    always_comb begin
        o_rsp_valid  = r_pv[READ_LAT-1];
        o_rsp_err    = r_pe[READ_LAT-1];
        o_rsp_data   = r_pd[READ_LAT-1];
        w_dbg_oor    = 64'(i_addr_debug) >= 64'(DEPTH);
        o_data_debug = w_dbg_oor ? '0 : r_mem[i_addr_debug[DEPTH_BITS-1:0]];
    end

endmodule

// File: tb/tb_byte_addr_data_memory.sv
// Directed bench for byte_addr_data_memory (NB_DATA=32, DEPTH=16, READ_LAT=3).
`timescale 1ns/1ps
module tb_byte_addr_data_memory;

    localparam int unsigned NB_DATA  = 32;
    localparam int unsigned DEPTH    = 16;
    localparam int unsigned NB_ADDR  = 32;
    localparam int unsigned READ_LAT = 3;

    logic        clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_clear = 1'b0;
    logic        i_req_valid = 1'b0;
    logic        o_req_ready;
    logic        i_req_we = 1'b0;
    logic [1:0]  i_req_size = 2'b00;
    logic        i_req_unsigned = 1'b0;
    logic [31:0] i_req_addr = '0;
    logic [31:0] i_req_wdata = '0;
    logic        o_rsp_valid;
    logic [31:0] o_rsp_data;
    logic        o_rsp_err;
    logic [31:0] i_addr_debug = '0;
    logic [31:0] o_data_debug;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] model [DEPTH];

    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    byte_addr_data_memory #(
        .NB_DATA(NB_DATA), .DEPTH(DEPTH), .NB_ADDR(NB_ADDR), .READ_LAT(READ_LAT)
    ) dut (
        .i_clk(clk), .i_rst_n(i_rst_n), .i_clear(i_clear),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_we(i_req_we), .i_req_size(i_req_size), .i_req_unsigned(i_req_unsigned),
        .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
        .o_rsp_valid(o_rsp_valid), .o_rsp_data(o_rsp_data), .o_rsp_err(o_rsp_err),
        .i_addr_debug(i_addr_debug), .o_data_debug(o_data_debug)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
        i_req_valid    = 1'b1;
        i_req_we       = we;
        i_req_size     = size;
        i_req_unsigned = uns;
        i_req_addr     = addr;
        i_req_wdata    = wdata;
    endtask

    // Single request; returns ready at issue, response fields and observed latency
    task automatic issue(input vec_t v, output logic rdy, output logic [31:0] data,
                         output logic err, output int lat);
        @(negedge clk);
        drive(v.we, v.size, v.uns, v.addr, v.wdata);
        #1 rdy = o_req_ready;
        @(posedge clk);
        @(negedge clk);
        i_req_valid = 1'b0;
        lat = 1;
        while (!o_rsp_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        data = o_rsp_data;
        err  = o_rsp_err;
    endtask

    task automatic test_reset;
        int cnt;
        vec_t v;
        logic rdy, err;
        logic [31:0] data;
        int lat;
        i_rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++;
        if ({o_req_ready, o_rsp_valid, o_rsp_err} !== 3'b000 || o_rsp_data !== 32'h0) begin
            n_err++;
            $display("FAIL reset_outputs: rdy=%b vld=%b err=%b data=%h, want all 0",
                     o_req_ready, o_rsp_valid, o_rsp_err, o_rsp_data);
        end
        i_rst_n = 1'b1;
        cnt = 0;
        while (!o_req_ready && cnt < 4 * int'(DEPTH)) begin
            @(negedge clk);
            cnt++;
        end
        n_vec++;
        if (cnt !== int'(DEPTH)) begin
            n_err++;
            $display("FAIL reset_init_len: ready after %0d cycles, want %0d", cnt, DEPTH);
        end
        for (int i = 0; i < int'(DEPTH); i++) model[i] = 32'h0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            i_addr_debug = 32'(i);
            #1;
            n_vec++;
            if (o_data_debug !== model[i]) begin
                n_err++;
                $display("FAIL reset_zero[%0d]: got %h, want %h", i, o_data_debug, model[i]);
            end
        end
        v = '{1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0};
        issue(v, rdy, data, err, lat);
        n_vec++;
        if (rdy !== 1'b1 || lat !== int'(READ_LAT) || data !== 32'h0 || err !== 1'b0) begin
            n_err++;
            $display("FAIL reset_load0: rdy=%b lat=%0d data=%h err=%b, want 1/%0d/00000000/0",
                     rdy, lat, data, err, READ_LAT);
        end
    endtask

    task automatic test_store_load_byte;
        vec_t tv [7];
        logic rdy, err;
        logic [31:0] data;
        int lat;
        tv[0] = '{1'b1, 2'b10, 1'b0, 32'h10, 32'h8000_00FF, 32'h0,         1'b0};
        tv[1] = '{1'b0, 2'b00, 1'b0, 32'h10, 32'h0,        32'hFFFF_FFFF, 1'b0};
        tv[2] = '{1'b0, 2'b00, 1'b1, 32'h10, 32'h0,        32'h0000_00FF, 1'b0};
        tv[3] = '{1'b0, 2'b00, 1'b0, 32'h13, 32'h0,        32'hFFFF_FF80, 1'b0};
        tv[4] = '{1'b0, 2'b01, 1'b1, 32'h12, 32'h0,        32'h0000_8000, 1'b0};
        tv[5] = '{1'b0, 2'b01, 1'b0, 32'h12, 32'h0,        32'hFFFF_8000, 1'b0};
        tv[6] = '{1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        32'h8000_00FF, 1'b0};
        model[4] = 32'h8000_00FF;
        for (int i = 0; i < 7; i++) begin
            issue(tv[i], rdy, data, err, lat);
            n_vec++;
            if (rdy !== 1'b1 || lat !== int'(READ_LAT) || data !== tv[i].exp_data || err !== tv[i].exp_err) begin
                n_err++;
                $display("FAIL byte_ext[%0d]: rdy=%b lat=%0d data=%h err=%b, want 1/%0d/%h/%b",
                         i, rdy, lat, data, err, READ_LAT, tv[i].exp_data, tv[i].exp_err);
            end
        end
    endtask

    task automatic test_half_merge;
        vec_t tv [5];
        logic rdy, err;
        logic [31:0] data;
        int lat;
        tv[0] = '{1'b1, 2'b10, 1'b0, 32'h20, 32'hAAAA_AAAA, 32'h0,         1'b0};
        tv[1] = '{1'b1, 2'b01, 1'b0, 32'h22, 32'hFFFF_1234, 32'h0,         1'b0};
        tv[2] = '{1'b0, 2'b10, 1'b0, 32'h20, 32'h0,        32'h1234_AAAA, 1'b0};
        tv[3] = '{1'b1, 2'b00, 1'b0, 32'h21, 32'h1234_565A, 32'h0,         1'b0};
        tv[4] = '{1'b0, 2'b10, 1'b1, 32'h20, 32'h0,        32'h1234_5AAA, 1'b0};
        model[8] = 32'h1234_5AAA;
        for (int i = 0; i < 5; i++) begin
            issue(tv[i], rdy, data, err, lat);
            n_vec++;
            if (rdy !== 1'b1 || lat !== int'(READ_LAT) || data !== tv[i].exp_data || err !== tv[i].exp_err) begin
                n_err++;
                $display("FAIL half_merge[%0d]: rdy=%b lat=%0d data=%h err=%b, want 1/%0d/%h/%b",
                         i, rdy, lat, data, err, READ_LAT, tv[i].exp_data, tv[i].exp_err);
            end
        end
    endtask

    task automatic test_errors;
        vec_t tv [7];
        logic rdy, err;
        logic [31:0] data;
        int lat;
        tv[0] = '{1'b0, 2'b10, 1'b0, 32'h11,        32'h0,        32'h0,         1'b1};
        tv[1] = '{1'b0, 2'b01, 1'b0, 32'h13,        32'h0,        32'h0,         1'b1};
        tv[2] = '{1'b1, 2'b10, 1'b0, 32'h40,        32'h5555_5555, 32'h0,        1'b1};
        tv[3] = '{1'b1, 2'b00, 1'b0, 32'h41,        32'h0000_0077, 32'h0,        1'b1};
        tv[4] = '{1'b1, 2'b11, 1'b0, 32'h0,         32'h9999_9999, 32'h0,        1'b1};
        tv[5] = '{1'b0, 2'b10, 1'b0, 32'hFFFF_FFFC, 32'h0,        32'h0,         1'b1};
        tv[6] = '{1'b1, 2'b01, 1'b0, 32'h11,        32'hBEEF,     32'h0,         1'b1};
        for (int i = 0; i < 7; i++) begin
            issue(tv[i], rdy, data, err, lat);
            n_vec++;
            if (rdy !== 1'b1 || lat !== int'(READ_LAT) || data !== tv[i].exp_data || err !== tv[i].exp_err) begin
                n_err++;
                $display("FAIL error_rsp[%0d]: rdy=%b lat=%0d data=%h err=%b, want 1/%0d/%h/%b",
                         i, rdy, lat, data, err, READ_LAT, tv[i].exp_data, tv[i].exp_err);
            end
        end
        for (int i = 0; i <= int'(DEPTH); i++) begin
            i_addr_debug = 32'(i);
            #1;
            n_vec++;
            if (o_data_debug !== ((i == int'(DEPTH)) ? 32'h0 : model[i % int'(DEPTH)])) begin
                n_err++;
                $display("FAIL error_nowrite[%0d]: got %h, want %h", i, o_data_debug,
                         (i == int'(DEPTH)) ? 32'h0 : model[i % int'(DEPTH)]);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic        v [10];
        logic        e [10];
        logic [31:0] d [10];
        logic [31:0] wv [3];
        vec_t st;
        logic rdy, err;
        logic [31:0] data;
        int lat;
        wv[0] = 32'h0102_0304;
        wv[1] = 32'hA5A5_5A5A;
        wv[2] = 32'hDEAD_BEEF;
        for (int k = 0; k < 3; k++) begin
            st = '{1'b1, 2'b10, 1'b0, 32'(4 * k), wv[k], 32'h0, 1'b0};
            issue(st, rdy, data, err, lat);
            model[k] = wv[k];
        end
        // Three loads in consecutive cycles
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c < 3) drive(1'b0, 2'b10, 1'b0, 32'(4 * c), 32'h0);
            else i_req_valid = 1'b0;
            #1;
            v[c] = o_rsp_valid; d[c] = o_rsp_data; e[c] = o_rsp_err;
        end
        for (int c = 0; c < 10; c++) begin
            n_vec++;
            if (v[c] !== (c >= 3 && c <= 5) || e[c] !== 1'b0 ||
                d[c] !== ((c >= 3 && c <= 5) ? wv[(c + 7) % 10 % 3] : 32'h0)) begin
                n_err++;
                $display("FAIL b2b_load[%0d]: vld=%b data=%h err=%b, want %b/%h/0", c, v[c], d[c], e[c],
                         (c >= 3 && c <= 5), (c >= 3 && c <= 5) ? wv[(c + 7) % 10 % 3] : 32'h0);
            end
        end
        // Store immediately followed by a load of the same word
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c == 0) drive(1'b1, 2'b10, 1'b0, 32'h0, 32'hCAFE_F00D);
            else if (c == 1) drive(1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
            else i_req_valid = 1'b0;
            #1;
            v[c] = o_rsp_valid; d[c] = o_rsp_data; e[c] = o_rsp_err;
        end
        model[0] = 32'hCAFE_F00D;
        for (int c = 0; c < 8; c++) begin
            n_vec++;
            if (v[c] !== (c == 3 || c == 4) || e[c] !== 1'b0 ||
                d[c] !== ((c == 4) ? 32'hCAFE_F00D : 32'h0)) begin
                n_err++;
                $display("FAIL st_ld_fwd[%0d]: vld=%b data=%h err=%b, want %b/%h/0", c, v[c], d[c], e[c],
                         (c == 3 || c == 4), (c == 4) ? 32'hCAFE_F00D : 32'h0);
            end
        end
    endtask

    task automatic test_clear;
        localparam int N = int'(DEPTH) + 8;
        logic        r [N];
        logic        v [N];
        logic [31:0] d [N];
        logic        exp_r, exp_v;
        logic [31:0] exp_d;
        for (int c = 0; c < N; c++) begin
            @(negedge clk);
            i_clear = (c == 2);
            if (c == 0) drive(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
            else if (c == 1) drive(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
            else if (c == 2) drive(1'b0, 2'b10, 1'b0, 32'h4, 32'h0);
            else i_req_valid = 1'b0;
            #1;
            r[c] = o_req_ready; v[c] = o_rsp_valid; d[c] = o_rsp_data;
        end
        i_clear = 1'b0;
        for (int c = 0; c < N; c++) begin
            exp_r = (c < 2) || (c >= 3 + int'(DEPTH));
            exp_v = (c == 3) || (c == 4);
            exp_d = (c == 3) ? 32'h8000_00FF : (c == 4) ? 32'h1234_5AAA : 32'h0;
            n_vec++;
            if (r[c] !== exp_r || v[c] !== exp_v || d[c] !== exp_d) begin
                n_err++;
                $display("FAIL clear_seq[%0d]: rdy=%b vld=%b data=%h, want %b/%b/%h",
                         c, r[c], v[c], d[c], exp_r, exp_v, exp_d);
            end
        end
        for (int i = 0; i < int'(DEPTH); i++) model[i] = 32'h0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            i_addr_debug = 32'(i);
            #1;
            n_vec++;
            if (o_data_debug !== model[i]) begin
                n_err++;
                $display("FAIL clear_zero[%0d]: got %h, want %h", i, o_data_debug, model[i]);
            end
        end
    endtask

    task automatic test_reset_inflight;
        int seen;
        int cnt;
        @(negedge clk);
        drive(1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
        @(posedge clk);
        @(negedge clk);
        i_req_valid = 1'b0;
        i_rst_n = 1'b0;
        #1;
        n_vec++;
        if ({o_req_ready, o_rsp_valid, o_rsp_err} !== 3'b000 || o_rsp_data !== 32'h0) begin
            n_err++;
            $display("FAIL rst_async: rdy=%b vld=%b err=%b data=%h, want all 0",
                     o_req_ready, o_rsp_valid, o_rsp_err, o_rsp_data);
        end
        @(negedge clk);
        i_rst_n = 1'b1;
        seen = 0;
        cnt = 0;
        while (!o_req_ready && cnt < 4 * int'(DEPTH)) begin
            @(negedge clk);
            cnt++;
            if (o_rsp_valid) seen++;
        end
        n_vec++;
        if (seen !== 0) begin
            n_err++;
            $display("FAIL rst_drop: %0d responses after reset, want 0", seen);
        end
        n_vec++;
        if (cnt !== int'(DEPTH)) begin
            n_err++;
            $display("FAIL rst_reinit_len: ready after %0d cycles, want %0d", cnt, DEPTH);
        end
    endtask

    initial begin
        test_reset();
        test_store_load_byte();
        test_half_merge();
        test_errors();
        test_back_to_back();
        test_clear();
        test_reset_inflight();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/byte_addr_data_memory.md
BYTE_ADDR_DATA_MEMORY -- requirements
Module: byte_addr_data_memory

Interface
REQ-001 SHALL have parameter NB_DATA, default 32, word width in bits; legal values 32 or 64.
REQ-002 SHALL have parameter DEPTH, default 1024, number of words; power of two.
REQ-003 SHALL have parameter NB_ADDR, default 32, byte-address width.
REQ-004 SHALL have parameter READ_LAT, default 1, request-to-response latency in cycles; legal 1..4.
REQ-005 SHALL have port i_clk  in  1  sole clock; all state on rising edge.
REQ-006 SHALL have port i_rst_n  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port i_clear  in  1  request to re-zero the whole array.
REQ-008 SHALL have port i_req_valid  in  1  access request present.
REQ-009 SHALL have port o_req_ready  out  1  block accepts a request this cycle.
REQ-010 SHALL have port i_req_we  in  1  1 = store, 0 = load.
REQ-011 SHALL have port i_req_size  in  2  00 byte, 01 half, 10 word, 11 dword.
REQ-012 SHALL have port i_req_unsigned  in  1  1 = zero-extend loads, 0 = sign-extend.
REQ-013 SHALL have port i_req_addr  in  NB_ADDR  byte address.
REQ-014 SHALL have port i_req_wdata  in  NB_DATA  store data, right-justified.
REQ-015 SHALL have port o_rsp_valid  out  1  response present; one cycle per accepted request.
REQ-016 SHALL have port o_rsp_data  out  NB_DATA  extended load data; 0 for stores and errors.
REQ-017 SHALL have port o_rsp_err  out  1  access rejected: misaligned, out of range, or illegal size.
REQ-018 SHALL have port i_addr_debug  in  NB_ADDR  word index for debug read.
REQ-019 SHALL have port o_data_debug  out  NB_DATA  combinational raw word at i_addr_debug; 0 if index >= DEPTH.

Function
REQ-020 SHALL derive word index = i_req_addr >> log2(NB_DATA/8) and lane offset = the low log2(NB_DATA/8) address bits.
REQ-021 SHALL flag an error when any of these holds: index >= DEPTH; the address is not aligned to the access size; size 11 is used with NB_DATA = 32.
REQ-022 SHALL accept a request on a rising edge where i_req_valid and o_req_ready are both 1.
REQ-023 SHALL, for an accepted error-free store, write only the byte lanes covered by size and offset on the accept edge; store data SHALL come from the low bytes of i_req_wdata.
REQ-024 SHALL never modify the array for an errored store.
REQ-025 SHALL, for an accepted load, sample the addressed word on the accept edge, shift the selected lanes to bit 0, and then sign- or zero-extend per i_req_unsigned.
REQ-026 SHALL make a load accepted on the cycle after a store to the same word return the stored data.
REQ-027 SHALL present each accepted request's response exactly READ_LAT cycles after acceptance, in order, with a throughput of one per cycle and no backpressure.
REQ-028 SHALL, on error, drive o_rsp_err = 1 and o_rsp_data = 0; on a non-error response o_rsp_err = 0; stores respond with o_rsp_data = 0.
REQ-029 SHALL hold o_rsp_data = 0 and o_rsp_err = 0 when o_rsp_valid = 0.
REQ-030 SHALL implement a two-state FSM: INIT clears word cnt and increments cnt each cycle; when cnt = DEPTH-1 it goes to RUN; RUN goes to INIT on i_clear = 1, resetting cnt to 0.
REQ-031 SHALL drive o_req_ready = 1 only in RUN with i_clear = 0; a request coinciding with i_clear is not accepted.
REQ-032 SHALL keep the response pipeline advancing during INIT, so in-flight responses still emerge with their original data.
REQ-033 SHALL ignore i_clear in INIT; a clear takes exactly DEPTH cycles.

Reset
REQ-034 SHALL, on i_rst_n = 0, immediately force state INIT, cnt 0, all pipeline valids 0, o_req_ready 0, o_rsp_valid 0, o_rsp_data 0, o_rsp_err 0.
REQ-035 SHALL, after i_rst_n rises, spend DEPTH cycles in INIT and then leave every word at 0.
REQ-036 SHALL drop responses in flight when reset is asserted mid-operation; none are produced after release.

Verification
REQ-037 Bench SHALL check this case: after reset, o_req_ready stays low for DEPTH cycles, then goes high, and a word load at 0x0 returns 0x00000000.
REQ-038 Bench SHALL check this case: store word 0x8000_00FF to 0x10, then load byte at 0x10 signed -> 0xFFFFFFFF, unsigned -> 0x000000FF, and load byte at 0x13 signed -> 0xFFFFFF80.
REQ-039 Bench SHALL check this case: store half 0x1234 at 0x22 over word 0xAAAA_AAAA at 0x20, then load word 0x20 -> 0x1234_AAAA.
REQ-040 Bench SHALL check this case: load word at 0x11 -> err 1, data 0; store to index DEPTH -> err 1, and the debug read of all words is unchanged.
REQ-041 Bench SHALL check this case: with READ_LAT = 3, back-to-back loads at 0x0/0x4/0x8 give three consecutive responses, the first valid exactly 3 cycles after the first accept.
REQ-042 Bench SHALL check this case: assert i_clear with two loads in flight, then both responses return their pre-clear data, ready stays low DEPTH cycles, and all words read 0 afterwards.
